// File: rtl/ram_block_mover.sv
// Avalon-MM block COPY/FILL engine driving the single-port on-chip data RAM.
// COPY costs 3 cycles/word, FILL 1 cycle/word, done pulses one cycle after the last write; commands are taken only while cmd_ready is high and are never queued.
module ram_block_mover #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t              state, state_nxt;
  logic                mode_q;
  logic                desc_q;
  logic [ADDR_W-1:0]   src_ptr, dst_ptr;
  logic [LEN_W-1:0]    remaining;
  logic [DATA_W-1:0]   data_q, fill_q;
  logic                cmd_desc;
  logic [ADDR_W-1:0]   len_off;

  // Descending copy keeps overlapping ranges with dst above src intact.
  assign cmd_desc = !cmd_mode && (cmd_dst > cmd_src);
  assign len_off  = ADDR_W'(cmd_len - LEN_ONE);

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state == RD) || (state == CAP) || (state == WR);
  assign done           = (state == FIN);
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_writedata  = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0)  state_nxt = FIN;
          else if (cmd_mode)  state_nxt = WR;
          else                state_nxt = RD;
        end
      end
      RD: begin
        ram_chipselect = 1'b1;
        ram_address    = src_ptr;
        state_nxt      = abort ? FIN : CAP;
      end
      CAP: state_nxt = abort ? FIN : WR;
      WR: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = dst_ptr;
        ram_writedata  = mode_q ? fill_q : data_q;
        if (abort || remaining == LEN_ONE) state_nxt = FIN;
        else if (!mode_q)                  state_nxt = RD;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= 1'b0;
      desc_q     <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      data_q     <= '0;
      fill_q     <= '0;
      words_done <= '0;
      aborted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode_q     <= cmd_mode;
            fill_q     <= cmd_fill;
            desc_q     <= cmd_desc;
            src_ptr    <= cmd_desc ? cmd_src + len_off : cmd_src;
            dst_ptr    <= cmd_desc ? cmd_dst + len_off : cmd_dst;
            remaining  <= cmd_len;
            words_done <= '0;
            aborted    <= 1'b0;
          end
        end
        RD: begin
          if (abort) aborted <= 1'b1;
        end
        CAP: begin
          data_q <= ram_readdata;
          if (abort) aborted <= 1'b1;
        end
        WR: begin
          // The write driven this cycle commits even when aborting.
          words_done <= words_done + LEN_ONE;
          remaining  <= remaining - LEN_ONE;
          src_ptr    <= desc_q ? src_ptr - ADDR_ONE : src_ptr + ADDR_ONE;
          dst_ptr    <= desc_q ? dst_ptr - ADDR_ONE : dst_ptr + ADDR_ONE;
          if (abort) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM, access logger and a per-command
// reference model built from word order, cycle cost and abort rules.
module tb_ram_block_mover;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_fill = '0;
  logic          abort = 1'b0;
  logic          busy, done, aborted;
  logic [LW-1:0] words_done;
  logic [AW-1:0] ram_address;
  logic [DW/8-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_rdata = '0;

  ram_block_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_rdata)
  );

  typedef struct {int t; bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} acc_t;

  acc_t          log_q[$];
  acc_t          exp_q[$];
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] exp_mem [1024];
  int            cyc = 0;
  int            base = 0;
  int            checks = 0;
  int            failures = 0;
  int            exp_done, exp_words;
  bit            exp_ab;
  int            done_cyc, got_wd;
  bit            got_ab, busy1, rdy_poke;
  logic          l_cs, l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM outputs are stable in the second half of the cycle; latch and log them there.
  always @(negedge clk) begin
    l_cs   = ram_chipselect;
    l_we   = ram_write;
    l_addr = ram_address;
    l_wd   = ram_writedata;
    if (reset_n && ram_chipselect) log_q.push_back('{cyc, ram_write, ram_address, ram_writedata});
  end

  always @(posedge clk) begin
    if (l_cs) begin
      if (l_we) mem[l_addr] <= l_wd;
      else      ram_rdata   <= mem[l_addr];
    end
  end

  function automatic void set_word(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endfunction

  // Expected accesses, final memory, completion cycle and counts for one command.
  function automatic void build_expected(input bit mode, input logic [AW-1:0] src,
                                         input logic [AW-1:0] dst, input int len,
                                         input logic [DW-1:0] fill, input int abort_at);
    int normal, lim, so, dof;
    bit desc, eff;
    logic [AW-1:0] s, d;
    logic [DW-1:0] v;
    exp_q.delete();
    exp_words = 0;
    normal = (len == 0) ? 1 : (mode ? len + 1 : 3 * len + 1);
    eff    = (abort_at >= 1) && (abort_at < normal);
    lim    = eff ? abort_at : normal;
    desc   = !mode && (dst > src);
    for (int i = 0; i < len; i++) begin
      so  = desc ? int'(src) + len - 1 - i : int'(src) + i;
      dof = desc ? int'(dst) + len - 1 - i : int'(dst) + i;
      s   = AW'(so % 1024);
      d   = AW'(dof % 1024);
      if (mode) begin
        if (1 + i <= lim) begin
          exp_q.push_back('{1 + i, 1'b1, d, fill});
          exp_mem[d] = fill;
          exp_words++;
        end
      end else begin
        if (1 + 3 * i <= lim) exp_q.push_back('{1 + 3 * i, 1'b0, s, 32'h0});
        if (3 + 3 * i <= lim) begin
          v = exp_mem[s];
          exp_q.push_back('{3 + 3 * i, 1'b1, d, v});
          exp_mem[d] = v;
          exp_words++;
        end
      end
    end
    exp_done = eff ? abort_at + 1 : normal;
    exp_ab   = eff;
  endfunction

  function automatic int log_diff();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (log_q[i].t - base != exp_q[i].t || log_q[i].we != exp_q[i].we ||
          log_q[i].addr !== exp_q[i].addr || (exp_q[i].we && log_q[i].data !== exp_q[i].data))
        return i;
    end
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int mem_diff();
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) return i;
    return -1;
  endfunction

  task automatic run_cmd(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input int len, input logic [DW-1:0] fill, input int abort_at,
                         input int poke_at);
    build_expected(mode, src, dst, len, fill, abort_at);
    log_q.delete();
    @(posedge clk); #1;
    cmd_mode = mode; cmd_src = src; cmd_dst = dst; cmd_len = LW'(len); cmd_fill = fill;
    cmd_valid = 1'b1;
    base = cyc;
    done_cyc = -1; got_wd = -1; got_ab = 1'b0; busy1 = 1'b0; rdy_poke = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      cmd_valid = (k == poke_at);
      if (k == poke_at) begin
        cmd_mode = 1'b0; cmd_src = 10'h2AA; cmd_dst = 10'h155; cmd_len = 11'd7;
        rdy_poke = cmd_ready;
      end
      abort = (k == abort_at);
      if (k == 1) busy1 = busy;
      if (done) begin
        done_cyc = k; got_wd = int'(words_done); got_ab = aborted;
        break;
      end
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, cmd_ready, ram_chipselect, ram_write, ram_clken, ram_byteenable} !== 11'b000_1_00_1_1111) begin
      failures++;
      $display("FAIL reset_flags got=%b want=%b", {busy, done, aborted, cmd_ready, ram_chipselect, ram_write, ram_clken, ram_byteenable}, 11'b000_1_00_1_1111);
    end
    checks++;
    if ({words_done, ram_address, ram_writedata} !== '0) begin
      failures++;
      $display("FAIL reset_values got wd=%0d addr=%h wdata=%h want all zero", words_done, ram_address, ram_writedata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) set_word(16 + i, $urandom);
    run_cmd(1'b1, 10'h010, 10'h010, 4, 32'hDEADBEEF, 0, 0);
    checks++; if (done_cyc !== 5) begin failures++; $display("FAIL fill_done_cycle got=%0d want=5", done_cyc); end
    checks++; if (got_wd !== 4) begin failures++; $display("FAIL fill_words_done got=%0d want=4", got_wd); end
    checks++; if (log_diff() != -1) begin failures++; $display("FAIL fill_access_order first_bad_index=%0d want=-1", log_diff()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16 + i] !== 32'hDEADBEEF) begin failures++; $display("FAIL fill_readback addr=%0h got=%h want=deadbeef", 16 + i, mem[16 + i]); end
    end
    checks++; if (mem_diff() != -1) begin failures++; $display("FAIL fill_memory first_bad_addr=%0h want=none", mem_diff()); end
  endtask

  task automatic test_copy();
    set_word(0, 32'd1); set_word(1, 32'd2); set_word(2, 32'd3);
    run_cmd(1'b0, 10'h000, 10'h100, 3, 32'h0, 0, 0);
    checks++; if (done_cyc !== 10) begin failures++; $display("FAIL copy_done_cycle got=%0d want=10", done_cyc); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL copy_busy got=%b want=1", busy1); end
    checks++; if (log_diff() != -1) begin failures++; $display("FAIL copy_access_order first_bad_index=%0d want=-1", log_diff()); end
    checks++;
    if ({mem[256], mem[257], mem[258]} !== {32'd1, 32'd2, 32'd3}) begin
      failures++; $display("FAIL copy_data got=%0h,%0h,%0h want=1,2,3", mem[256], mem[257], mem[258]);
    end
  endtask

  task automatic test_overlap();
    set_word(32, 32'hA); set_word(33, 32'hB); set_word(34, 32'hC); set_word(35, 32'hD);
    run_cmd(1'b0, 10'h020, 10'h022, 4, 32'h0, 0, 0);
    checks++;
    if (log_q.size() < 2 || log_q[0].addr !== 10'h023 || log_q[0].we || log_q[1].addr !== 10'h025 || !log_q[1].we) begin
      failures++; $display("FAIL overlap_first_access got_entries=%0d want R023 then W025", log_q.size());
    end
    checks++;
    if ({mem[34], mem[35], mem[36], mem[37]} !== {32'hA, 32'hB, 32'hC, 32'hD}) begin
      failures++; $display("FAIL overlap_data got=%0h,%0h,%0h,%0h want=a,b,c,d", mem[34], mem[35], mem[36], mem[37]);
    end
    checks++; if (log_diff() != -1) begin failures++; $display("FAIL overlap_access_order first_bad_index=%0d want=-1", log_diff()); end
    checks++; if (done_cyc !== 13) begin failures++; $display("FAIL overlap_done_cycle got=%0d want=13", done_cyc); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] keep;
    set_word(2, 32'h1234_5678);
    keep = mem[2];
    run_cmd(1'b1, 10'h000, 10'h3FE, 4, 32'h55, 0, 0);
    checks++;
    if ({mem[1022], mem[1023], mem[0], mem[1]} !== {4{32'h55}}) begin
      failures++; $display("FAIL wrap_data got=%0h,%0h,%0h,%0h want=55 x4", mem[1022], mem[1023], mem[0], mem[1]);
    end
    checks++; if (mem[2] !== keep) begin failures++; $display("FAIL wrap_untouched got=%h want=%h", mem[2], keep); end
    checks++; if (log_diff() != -1) begin failures++; $display("FAIL wrap_access_order first_bad_index=%0d want=-1", log_diff()); end
  endtask

  task automatic test_len0_and_busy();
    run_cmd(1'b0, 10'h050, 10'h060, 0, 32'h0, 0, 0);
    checks++; if (log_q.size() != 0) begin failures++; $display("FAIL len0_no_access got=%0d accesses want=0", log_q.size()); end
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL len0_done_cycle got=%0d want=1", done_cyc); end
    checks++; if (got_wd !== 0) begin failures++; $display("FAIL len0_words_done got=%0d want=0", got_wd); end
    run_cmd(1'b1, 10'h000, 10'h200, 6, 32'hC0FFEE00, 0, 2);
    checks++; if (rdy_poke !== 1'b0) begin failures++; $display("FAIL busy_cmd_ready got=%b want=0", rdy_poke); end
    checks++; if (done_cyc !== 7) begin failures++; $display("FAIL busy_done_cycle got=%0d want=7", done_cyc); end
    checks++; if (log_diff() != -1) begin failures++; $display("FAIL busy_access_order first_bad_index=%0d want=-1", log_diff()); end
    checks++; if (mem_diff() != -1) begin failures++; $display("FAIL busy_memory first_bad_addr=%0h want=none", mem_diff()); end
  endtask

  task automatic test_abort();
    run_cmd(1'b1, 10'h000, 10'h180, 10, 32'hABCD0001, 3, 0);
    checks++; if (got_wd !== 3) begin failures++; $display("FAIL abort_words_done got=%0d want=3", got_wd); end
    checks++; if (got_ab !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b want=1", got_ab); end
    checks++; if (done_cyc !== 4) begin failures++; $display("FAIL abort_done_cycle got=%0d want=4", done_cyc); end
    checks++; if (mem_diff() != -1) begin failures++; $display("FAIL abort_memory first_bad_addr=%0h want=none", mem_diff()); end
    @(posedge clk); #1;
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL abort_flag_held got=%b want=1", aborted); end
    run_cmd(1'b1, 10'h000, 10'h190, 1, 32'h1, 0, 0);
    checks++; if (got_ab !== 1'b0) begin failures++; $display("FAIL abort_cleared got=%b want=0", got_ab); end
  endtask

  task automatic test_async_reset();
    build_expected(1'b0, 10'h300, 10'h380, 20, 32'h0, 4);
    log_q.delete();
    @(posedge clk); #1;
    cmd_mode = 1'b0; cmd_src = 10'h300; cmd_dst = 10'h380; cmd_len = 11'd20; cmd_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    checks++;
    if ({busy, ram_chipselect, ram_write} !== 3'b110) begin
      failures++; $display("FAIL arst_pre_read got=%b want=110", {busy, ram_chipselect, ram_write});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, cmd_ready, ram_chipselect, ram_write, ram_clken, ram_byteenable} !== 11'b000_1_00_1_1111) begin
      failures++;
      $display("FAIL arst_flags got=%b want=%b", {busy, done, aborted, cmd_ready, ram_chipselect, ram_write, ram_clken, ram_byteenable}, 11'b000_1_00_1_1111);
    end
    checks++;
    if ({words_done, ram_address, ram_writedata} !== '0) begin
      failures++; $display("FAIL arst_values got wd=%0d addr=%h wdata=%h want all zero", words_done, ram_address, ram_writedata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL arst_idle got=%b want=10", {cmd_ready, busy}); end
    checks++; if (mem_diff() != -1) begin failures++; $display("FAIL arst_memory first_bad_addr=%0h want=none", mem_diff()); end
    run_cmd(1'b1, 10'h000, 10'h3C0, 5, 32'hA5A50F0F, 0, 0);
    checks++; if (done_cyc !== 6) begin failures++; $display("FAIL arst_recover_done got=%0d want=6", done_cyc); end
    checks++; if (mem_diff() != -1) begin failures++; $display("FAIL arst_recover_memory first_bad_addr=%0h want=none", mem_diff()); end
  endtask

  task automatic test_random();
    bit mode;
    logic [AW-1:0] src, dst;
    int len, ab_at;
    for (int it = 0; it < 30; it++) begin
      mode = 1'($urandom % 2);
      src  = AW'($urandom % 1024);
      dst  = ($urandom % 2 == 1) ? AW'((int'(src) + 1020 + int'($urandom_range(0, 8))) % 1024) : AW'($urandom % 1024);
      len  = (it == 29) ? 1024 : int'($urandom_range(0, 40));
      ab_at = ($urandom % 4 == 0) ? int'($urandom_range(1, mode ? len + 1 : 3 * len + 1)) : 0;
      run_cmd(mode, src, dst, len, $urandom, ab_at, 0);
      checks++; if (done_cyc !== exp_done) begin failures++; $display("FAIL rand%0d_done_cycle got=%0d want=%0d", it, done_cyc, exp_done); end
      checks++; if (got_wd !== exp_words) begin failures++; $display("FAIL rand%0d_words_done got=%0d want=%0d", it, got_wd, exp_words); end
      checks++; if (got_ab !== exp_ab) begin failures++; $display("FAIL rand%0d_aborted got=%b want=%b", it, got_ab, exp_ab); end
      checks++; if (log_diff() != -1) begin failures++; $display("FAIL rand%0d_access_order first_bad_index=%0d want=-1", it, log_diff()); end
      checks++; if (mem_diff() != -1) begin failures++; $display("FAIL rand%0d_memory first_bad_addr=%0h want=none", it, mem_diff()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    test_reset();
    test_fill();
    test_copy();
    test_overlap();
    test_wrap();
    test_len0_and_busy();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Avalon-MM master engine that sits directly upstream of the 1024x32 single-port on-chip data RAM.
- Drives that RAM's slave port (address, byteenable, chipselect, write, writedata, clken; reads readdata).
- Performs word-granular block COPY (RAM to RAM) or FILL (constant to RAM) on command.
- Frees the Nios core from clearing tile/sprite tables and moving game-state buffers.

Parameters:
ADDR_W, 10, RAM word-address width; the address space wraps modulo 2^ADDR_W.
DATA_W, 32, RAM data width; byteenable width is DATA_W/8.
LEN_W, 11, length field width; must be ADDR_W+1 so one command can cover the full RAM.

Ports:
clk  in  1  system clock, shared with the RAM.
reset_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request; accepted only in IDLE.
cmd_ready  out  1  high in IDLE.
cmd_mode  in  1  0=COPY, 1=FILL.
cmd_src  in  ADDR_W  source word address (COPY only).
cmd_dst  in  ADDR_W  destination word address.
cmd_len  in  LEN_W  number of words, 0..1024.
cmd_fill  in  DATA_W  fill value (FILL only).
abort  in  1  stop the current command.
busy  out  1  command in progress.
done  out  1  one-cycle completion pulse.
aborted  out  1  set with done if the command was aborted; held until the next accept.
words_done  out  LEN_W  words written by the current or last command.
ram_address  out  ADDR_W  RAM word address.
ram_byteenable  out  DATA_W/8  constant all-ones.
ram_chipselect  out  1  RAM access strobe.
ram_write  out  1  write qualifier.
ram_writedata  out  DATA_W  write data.
ram_clken  out  1  constant 1.
ram_readdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy=0, done=0, aborted=0, words_done=0, ram_chipselect=0, ram_write=0, ram_address=0, ram_writedata=0. ram_byteenable is all-ones and ram_clken=1 at all times, including during reset.
- RAM timing contract: an address presented with chipselect=1, write=0 in cycle N yields ram_readdata valid in cycle N+1, sampled at the end of N+1. A write with chipselect=1, write=1 in cycle N commits at the end of N.
- States: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch all cmd_* fields, clear words_done and aborted, set busy.
  - If cmd_len==0, go to FIN; no RAM access is made.
  - Otherwise go to RD for COPY, or WR for FILL.
- Direction (COPY only):
  - If cmd_dst > cmd_src (unsigned), copy descending. Pointers start at src+len-1 and dst+len-1 (mod 2^ADDR_W) and decrement.
  - Otherwise copy ascending from src and dst.
  - This makes overlapping non-wrapping ranges copy correctly.
  - If dst==src, still perform all reads and writes.
  - FILL is always ascending.
- RD: drive src pointer, chipselect=1, write=0. Go to CAP.
- CAP: chipselect=0. Register ram_readdata into the data register. Go to WR.
- WR:
  - Drive dst pointer, chipselect=1, write=1. writedata is the data register (COPY) or cmd_fill (FILL).
  - At the end of the cycle: words_done+1, step the pointers ±1 with wrap modulo 2^ADDR_W, decrement the remaining count.
  - If remaining reaches 0, go to FIN. Otherwise go to RD (COPY) or stay in WR (FILL).
- Throughput: COPY takes 3 cycles per word; FILL takes 1 cycle per word.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, chipselect=0. Next state is IDLE.
- abort:
  - Sampled in RD, CAP, or WR. Takes priority over the normal transition: go to FIN with aborted=1.
  - A write already driven in the abort cycle still commits and counts in words_done. No further accesses are made.
  - abort in IDLE or FIN is ignored.
- cmd_valid while busy: ignored (cmd_ready=0); the command is not queued.
- cmd_valid in the same cycle as done: not accepted; it is accepted in the following IDLE cycle.
- Address wrap: a FILL at dst=1020 with len=8 writes 1020..1023 then 0..3.
- cmd_len greater than 1024: truncated to LEN_W bits by width; software must not issue it.

Test Plan:
- FILL dst=0x010, len=4, fill=0xDEADBEEF -> writes on 4 consecutive cycles to 0x010..0x013; done 1 cycle after the last write; words_done=4; readback all 0xDEADBEEF.
- COPY src=0x000, dst=0x100, len=3, RAM[0..2]={1,2,3} -> access order R0,W100,R1,W101,R2,W102 at 3 cycles per word; RAM[0x100..0x102]={1,2,3}; done at cycle 10 after accept.
- Overlapping COPY src=0x020, dst=0x022, len=4, RAM[0x20..0x23]={A,B,C,D} -> descending order (R23/W25 first); final RAM[0x22..0x25]={A,B,C,D}.
- Wrap FILL dst=0x3FE, len=4, fill=0x55 -> writes at 0x3FE, 0x3FF, 0x000, 0x001; RAM[0x002] unchanged.
- len=0 -> no chipselect ever asserted; done pulses 1 cycle after accept; words_done=0. Also: cmd_valid during busy -> ignored.
- abort during the 3rd WR of a FILL len=10 -> exactly 3 words written; done and aborted=1 next cycle. Also: reset_n asserted mid-COPY -> all outputs return to reset values immediately (async) and state=IDLE.
